// File: rtl/dm_responder_if.sv
// Data-memory port between the CPU-side initiator (master) and the memory responder (slave).
interface dm_responder_if;
  logic        m_data_req;
  logic [31:0] m_data_addr;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_data_wdata;
  logic [31:0] m_data_rdata;
  logic        m_data_ready;
  logic        m_data_err;
  logic        m_data_busy;

  modport master (
    output m_data_req, m_data_addr, m_data_byteen, m_data_wdata,
    input  m_data_rdata, m_data_ready, m_data_err, m_data_busy
  );

  modport slave (
    input  m_data_req, m_data_addr, m_data_byteen, m_data_wdata,
    output m_data_rdata, m_data_ready, m_data_err, m_data_busy
  );
endinterface

// File: rtl/dm_responder.sv
// Data-memory responder: one request at a time, byte-lane writes, registered read data
// returned after WAIT_CYCLES wait states with ready/err/busy status.
module dm_responder #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter logic [31:0] BASE        = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic          clk,
  input  logic          reset,
  dm_responder_if.slave m_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_cnt;
  logic [31:0]           r_addr;
  logic [3:0]            r_be;
  logic [31:0]           r_wdata;
  logic [31:0]           r_rdata;
  logic                  r_err;
  logic [31:0]           r_mem [2**ADDR_WIDTH];

  logic                  w_accept;
  logic                  w_enter_resp;
  logic [31:0]           w_addr;
  logic [3:0]            w_be;
  logic [31:0]           w_wdata;
  logic [31:0]           w_off;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_in_range;
  logic                  w_be_ok;
  logic [31:0]           w_word;
  logic [31:0]           w_merged;
  logic                  w_commit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt   <= LP_WAIT;
        r_addr  <= m_data.m_data_addr;
        r_be    <= m_data.m_data_byteen;
        r_wdata <= m_data.m_data_wdata;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (m_data.m_data_req) w_next = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
      S_WAIT:  if (r_cnt == 4'd1) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    m_data.m_data_busy  = (r_state != S_IDLE);
    m_data.m_data_ready = (r_state == S_RESP);
    m_data.m_data_rdata = r_rdata;
    m_data.m_data_err   = r_err;
  end

  // With zero wait states the accept edge is also the response edge, so the
  // live request fields are used there instead of the not-yet-latched copies.
  always_comb begin
    w_accept     = (r_state == S_IDLE) && m_data.m_data_req;
    w_enter_resp = (w_next == S_RESP);
    w_addr       = (r_state == S_IDLE) ? m_data.m_data_addr   : r_addr;
    w_be         = (r_state == S_IDLE) ? m_data.m_data_byteen : r_be;
    w_wdata      = (r_state == S_IDLE) ? m_data.m_data_wdata  : r_wdata;
    w_off        = w_addr - BASE;
    w_in_range   = ((w_off >> (ADDR_WIDTH + 2)) == '0);
    w_idx        = w_off[ADDR_WIDTH+1:2];
    case (w_be)
      4'b0000, 4'b1111, 4'b0011, 4'b1100,
      4'b0001, 4'b0010, 4'b0100, 4'b1000: w_be_ok = 1'b1;
      default:                            w_be_ok = 1'b0;
    endcase
    w_word   = r_mem[w_idx];
    w_merged = w_word;
    for (int unsigned l = 0; l < 4; l++) begin
      if (w_be[l]) w_merged[8*l +: 8] = w_wdata[8*l +: 8];
    end
    w_commit = reset && w_enter_resp && w_in_range && w_be_ok && (w_be != 4'b0000);
  end

  always_ff @(posedge clk) begin
    if (w_commit) r_mem[w_idx] <= w_merged;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_enter_resp) begin
      if (w_in_range && w_be_ok) begin
        r_rdata <= w_merged;
        r_err   <= 1'b0;
      end else begin
        r_rdata <= '0;
        r_err   <= 1'b1;
      end
    end else if (r_state == S_RESP) begin
      r_err <= 1'b0;
    end
  end

endmodule
